paralelo_lane_arbiter: RTL and testbench



---
 rtl/paralelo_lane_arbiter.sv | 137 +++++++++++++
 tb/tb_paralelo_lane_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/paralelo_lane_arbiter.sv
// Word-rate lane controller: link training, then round-robin burst-limited arbitration
// between two show-ahead FIFOs. Define ARB_FIXED_PRIO_EN for fixed priority (source 0 first).
module paralelo_lane_arbiter #(
  parameter int                DATA_W      = 8,
  parameter int                TRAIN_WORDS = 4,
  parameter int                MAX_BURST   = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM    = 8'hBC
) (
  input  logic              clkf,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] fifo0_data,
  input  logic              fifo0_empty,
  output logic              fifo0_pop,
  input  logic [DATA_W-1:0] fifo1_data,
  input  logic              fifo1_empty,
  output logic              fifo1_pop,
  output logic [DATA_W:0]   paralelo,
  output logic              sel,
  output logic              active
);

  localparam int TW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_WORDS - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_ACTIVE} state_t;

  state_t            r_state;
  logic [TW-1:0]     r_train_cnt;
  logic [BW-1:0]     r_burst_cnt;
  logic [DATA_W:0]   r_paralelo;
  logic              r_sel;
  logic              r_active;

  logic              w_arb_en;
  logic              w_grant0;
  logic              w_grant1;
  logic [BW-1:0]     w_burst_nxt;
  logic [DATA_W:0]   w_idle_word;
  logic [DATA_W-1:0] w_gnt_data;

  assign w_idle_word = {1'b0, IDLE_SYM};
  // Pops are gated by reset and enable directly so an abort takes effect mid-cycle.
  assign w_arb_en    = (r_state == S_ACTIVE) && enable && !reset;

`ifdef ARB_FIXED_PRIO_EN
  assign w_grant0    = w_arb_en && !fifo0_empty;
  assign w_grant1    = w_arb_en && fifo0_empty && !fifo1_empty;
  assign w_burst_nxt = '0;
`else
  logic w_cur_ne;
  logic w_oth_ne;
  logic w_keep;
  logic w_switch;
  logic w_gnt_src;

  assign w_cur_ne  = r_sel ? !fifo1_empty : !fifo0_empty;
  assign w_oth_ne  = r_sel ? !fifo0_empty : !fifo1_empty;
  assign w_keep    = w_cur_ne && ((r_burst_cnt < BURST_MAX) || !w_oth_ne);
  assign w_switch  = !w_keep && w_oth_ne;
  assign w_gnt_src = w_keep ? r_sel : ~r_sel;
  assign w_grant0  = w_arb_en && (w_keep || w_switch) && !w_gnt_src;
  assign w_grant1  = w_arb_en && (w_keep || w_switch) &&  w_gnt_src;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_burst_nxt = '0;
    if (w_keep)
      w_burst_nxt = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + BW'(1);
    else if (w_switch)
      w_burst_nxt = BW'(1);
  end
`endif

  assign w_gnt_data = w_grant1 ? fifo1_data : fifo0_data;
  assign fifo0_pop  = w_grant0;
  assign fifo1_pop  = w_grant1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkf or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_train_cnt <= '0;
      r_burst_cnt <= '0;
      r_paralelo  <= '0;
      r_sel       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_paralelo  <= w_idle_word;
          r_train_cnt <= '0;
          r_burst_cnt <= '0;
          r_active    <= 1'b0;
          if (enable) r_state <= S_TRAIN;
        end
        S_TRAIN: begin
          r_paralelo <= w_idle_word;
          if (!enable) begin
            r_state     <= S_IDLE;
            r_train_cnt <= '0;
          end else if (r_train_cnt == TRAIN_LAST) begin
            r_state     <= S_ACTIVE;
            r_active    <= 1'b1;
            r_train_cnt <= '0;
          end else begin
            r_train_cnt <= r_train_cnt + TW'(1);
          end
        end
        S_ACTIVE: begin
          if (!enable) begin
            r_paralelo  <= w_idle_word;
            r_state     <= S_IDLE;
            r_active    <= 1'b0;
            r_burst_cnt <= '0;
          end else begin
            r_burst_cnt <= w_burst_nxt;
            if (w_grant0 || w_grant1) begin
              r_paralelo <= {1'b1, w_gnt_data};
              r_sel      <= w_grant1;
            end else begin
              r_paralelo <= w_idle_word;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign paralelo = r_paralelo;
  assign sel      = r_sel;
  assign active   = r_active;

endmodule

// File: tb/tb_paralelo_lane_arbiter.sv
// Directed bench for paralelo_lane_arbiter: bench-side show-ahead FIFO queues and
// hand-computed expected words; checks use immediate assertions.
module tb_paralelo_lane_arbiter;

  logic       clkf = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] fifo0_data, fifo1_data;
  logic       fifo0_empty, fifo1_empty;
  logic       fifo0_pop, fifo1_pop;
  logic [8:0] paralelo;
  logic       sel, active;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_pass = 0, n_fail = 0, n_total = 0;
  int pop0_cnt = 0, pop1_cnt = 0;

  paralelo_lane_arbiter dut (
    .clkf(clkf), .reset(reset), .enable(enable),
    .fifo0_data(fifo0_data), .fifo0_empty(fifo0_empty), .fifo0_pop(fifo0_pop),
    .fifo1_data(fifo1_data), .fifo1_empty(fifo1_empty), .fifo1_pop(fifo1_pop),
    .paralelo(paralelo), .sel(sel), .active(active)
  );

  always #5 clkf = ~clkf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    fifo0_data  = fifo0_empty ? 8'h00 : q0[0];
    fifo1_data  = fifo1_empty ? 8'h00 : q1[0];
  endtask

  // One word clock: sample pops before the edge, retire popped heads after it.
  task automatic tick();
    logic p0, p1;
    logic [7:0] tmp;
    #1;
    p0 = fifo0_pop;
    p1 = fifo1_pop;
    @(posedge clkf);
    #1;
    if (p0) begin tmp = q0.pop_front(); pop0_cnt++; end
    if (p1) begin tmp = q1.pop_front(); pop1_cnt++; end
    drive_fifos();
    #1;
  endtask

  // IDLE->TRAIN edge plus TRAIN_WORDS training edges; active rises on the last one.
  task automatic train_to_active(input string tag);
    for (int i = 1; i <= 5; i++) begin
      check({tag, "_pops"}, {30'd0, fifo0_pop, fifo1_pop}, 32'd0);
      tick();
      check({tag, "_word"}, {23'd0, paralelo}, 32'h0BC);
      check({tag, "_active"}, {31'd0, active}, (i == 5) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic [8:0] exp3 [12];
    int p0_start, p1_start;

    reset = 1'b1;
    enable = 1'b0;
    drive_fifos();
    #2;
    check("rst_paralelo", {23'd0, paralelo}, 32'h000);
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_pops", {30'd0, fifo0_pop, fifo1_pop}, 32'd0);
    @(posedge clkf);
    #1;
    check("rst_hold", {23'd0, paralelo}, 32'h000);

    // 1: training with empty sources
    reset = 1'b0;
    enable = 1'b1;
    train_to_active("t1");
    tick();
    check("t1_active_idle_word", {23'd0, paralelo}, 32'h0BC);
    check("t1_active_stays", {31'd0, active}, 32'd1);
    check("t1_no_pops", {30'd0, fifo0_pop, fifo1_pop}, 32'd0);

    // 2: three words from source 0 only
    q0 = '{8'hFF, 8'h55, 8'h00};
    drive_fifos();
    #1;
    p0_start = pop0_cnt;
    check("t2_pop0_now", {31'd0, fifo0_pop}, 32'd1);
    tick(); check("t2_w0", {23'd0, paralelo}, 32'h1FF);
    tick(); check("t2_w1", {23'd0, paralelo}, 32'h155);
    tick(); check("t2_w2", {23'd0, paralelo}, 32'h100);
    tick(); check("t2_idle", {23'd0, paralelo}, 32'h0BC);
    check("t2_pop0_count", pop0_cnt - p0_start, 32'd3);

    // 3: both sources loaded with six words each
    q0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    q1 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    drive_fifos();
    #1;
`ifdef ARB_FIXED_PRIO_EN
    exp3 = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105, 9'h106,
             9'h111, 9'h112, 9'h113, 9'h114, 9'h115, 9'h116};
`else
    exp3 = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h111, 9'h112,
             9'h113, 9'h114, 9'h105, 9'h106, 9'h115, 9'h116};
`endif
    p0_start = pop0_cnt;
    p1_start = pop1_cnt;
    for (int i = 0; i < 12; i++) begin
      check("t3_one_pop", {31'd0, fifo0_pop & fifo1_pop}, 32'd0);
      tick();
      check($sformatf("t3_word%0d", i), {23'd0, paralelo}, {23'd0, exp3[i]});
      check($sformatf("t3_sel%0d", i), {31'd0, sel}, {31'd0, exp3[i][4]});
    end
    tick();
    check("t3_idle_after", {23'd0, paralelo}, 32'h0BC);
    check("t3_pop_total", (pop0_cnt - p0_start) + (pop1_cnt - p1_start), 32'd12);

    // 4: source 0 alone past the burst limit
    q0 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    drive_fifos();
    #1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t4_word%0d", i), {23'd0, paralelo}, 32'h121 + i);
      check($sformatf("t4_sel%0d", i), {31'd0, sel}, 32'd0);
    end

    // 6: drop enable while source 1 has data, then re-enable
    q1 = '{8'h31, 8'h32, 8'h33};
    drive_fifos();
    #1;
    tick();
    check("t6_first", {23'd0, paralelo}, 32'h131);
    enable = 1'b0;
    #1;
    check("t6_pop1_gated", {31'd0, fifo1_pop}, 32'd0);
    tick();
    check("t6_idle_word", {23'd0, paralelo}, 32'h0BC);
    check("t6_inactive", {31'd0, active}, 32'd0);
    check("t6_not_popped", q1.size(), 32'd2);
    enable = 1'b1;
    train_to_active("t6_retrain");
    tick();
    check("t6_resume0", {23'd0, paralelo}, 32'h132);
    tick();
    check("t6_resume1", {23'd0, paralelo}, 32'h133);

    // 5: reset mid-burst, then retrain before data
    q0 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    drive_fifos();
    #1;
    tick(); check("t5_w0", {23'd0, paralelo}, 32'h141);
    tick(); check("t5_w1", {23'd0, paralelo}, 32'h142);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_paralelo", {23'd0, paralelo}, 32'h000);
    check("t5_rst_pops", {30'd0, fifo0_pop, fifo1_pop}, 32'd0);
    check("t5_rst_active", {31'd0, active}, 32'd0);
    tick();
    check("t5_rst_hold", {23'd0, paralelo}, 32'h000);
    check("t5_q_untouched", q0.size(), 32'd4);
    reset = 1'b0;
    train_to_active("t5_retrain");
    tick();
    check("t5_resume", {23'd0, paralelo}, 32'h143);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
